// File: rtl/div_unit.sv
// 32-bit signed divider with MIPS DIV semantics: restoring division, one quotient bit per clock.
// Results land in hi (remainder) and lo (quotient). done pulses once per request.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] r_q, r_d;
    logic [31:0] q_q, q_d;
    logic [31:0] d_q, d_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;
    logic [32:0] trial;

    // Shifted partial remainder minus |B|; bit 32 set means the subtraction went negative.
    assign trial = {r_q, q_q[31]} - {1'b0, d_q};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor == 32'd0) begin
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        r_d     = 32'd0;
                        q_d     = dividend[31] ? -dividend : dividend;
                        d_d     = divisor[31] ? -divisor : divisor;
                        qneg_d  = dividend[31] ^ divisor[31];
                        rneg_d  = dividend[31];
                        cnt_d   = 6'd0;
                        dz_d    = 1'b0;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (!trial[32]) begin
                    r_d = trial[31:0];
                    q_d = {q_q[30:0], 1'b1};
                end else begin
                    r_d = {r_q[30:0], q_q[31]};
                    q_d = {q_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                lo_d    = qneg_q ? -q_q : q_q;
                hi_d    = rneg_q ? -r_q : r_q;
                state_d = StDone;
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            r_q     <= 32'd0;
            q_q     <= 32'd0;
            d_q     <= 32'd0;
            cnt_q   <= 6'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == StCalc) || (state_q == StFix);
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at issue, a monitor checks each done.
// Reference results come from 64-bit signed arithmetic, not from the restoring algorithm.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] model_lo = 32'd0;
    logic [31:0] model_hi = 32'd0;

    div_unit u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: done high at cycle %0d with nothing expected", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("lo", lo, e.lo);
                chk("hi", hi, e.hi);
                chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Reference: MIPS DIV via 64-bit signed arithmetic (truncating division, remainder sign of A).
    task automatic push_expected(input logic [31:0] a, input logic [31:0] b, input int c0);
        exp_t   e;
        longint sa;
        longint sb;
        longint qq;
        longint rr;
        if (b == 32'd0) begin
            e.dz  = 1'b1;
            e.cyc = c0 + 1;
        end else begin
            sa       = longint'($signed(a));
            sb       = longint'($signed(b));
            qq       = sa / sb;
            rr       = sa % sb;
            model_lo = qq[31:0];
            model_hi = rr[31:0];
            e.dz     = 1'b0;
            e.cyc    = c0 + 34;
        end
        e.lo = model_lo;
        e.hi = model_hi;
        sb_q.push_back(e);
    endtask

    // Present a request, let one edge sample it, then scramble the operands.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit expect_it);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        if (expect_it) push_expected(a, b, cyc);
    endtask

    task automatic wait_done(input bit chk_busy, input int exp_busy);
        int busy_cnt;
        bit seen;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        if (chk_busy) chk("busy_cycles", busy_cnt, exp_busy);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (sb_q.size() != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          c0;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(32'd100, 32'd7, 1'b1);
        wait_done(1'b1, 33);
        issue(32'hFFFFFF9C, 32'd7, 1'b1);
        wait_done(1'b0, 0);
        issue(32'd100, 32'hFFFFFFF9, 1'b1);
        wait_done(1'b0, 0);
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_done(1'b0, 0);

        issue(32'd100, 32'd7, 1'b1);
        wait_done(1'b0, 0);
        issue(32'd5, 32'd0, 1'b1);
        wait_done(1'b1, 0);
        issue(32'd9, 32'd3, 1'b1);
        chk("dz_clear_at_accept", {31'd0, div_zero}, 32'd0);
        chk("hi_held_during_calc", hi, 32'd2);
        wait_done(1'b0, 0);

        // A start during CALC must be ignored entirely.
        issue(32'd50, 32'd5, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 32'd1;
        divisor  = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
        repeat (40) @(negedge clk);

        // Reset mid-CALC aborts silently.
        issue(32'd50, 32'd5, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        model_lo = 32'd0;
        model_hi = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'd7, 32'd2, 1'b1);
        wait_done(1'b0, 0);

        // Start held high: second request is taken on the first IDLE cycle after DONE.
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'hFFFFFFFD;
        @(posedge clk);
        #1;
        c0 = cyc;
        push_expected(32'd1000, 32'hFFFFFFFD, c0);
        dividend = 32'hFFFFF000;
        divisor  = 32'd9;
        while (cyc < c0 + 35) @(posedge clk);
        #1;
        start = 1'b0;
        push_expected(32'hFFFFF000, 32'd9, c0 + 35);
        wait_drain();

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFFFFFF;
                3:       b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            issue(a, b, 1'b1);
            wait_done(1'b0, 0);
        end
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the ports SHALL be named clk and reset.
REQ-002 Port list, clock and reset first:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request a division; sampled only in IDLE
- dividend  input  32  signed two's-complement dividend (A)
- divisor  input  32  signed two's-complement divisor (B)
- hi  output  32  remainder register
- lo  output  32  quotient register
- busy  output  1  high while a division is in progress (CALC or FIX)
- done  output  1  one-cycle completion pulse
- div_zero  output  1  divide-by-zero flag for the latest request
REQ-003 The block SHALL have no parameters; all datapaths are fixed at 32 bits.

Function
REQ-004 The block SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-005 IDLE:
- start=1, divisor!=0: capture abs(dividend) and abs(divisor), the quotient sign (sign A XOR sign B) and the remainder sign (sign A); clear the 6-bit iteration counter; go to CALC.
- start=1, divisor==0: go to DONE with div_zero set.
- start=0: stay in IDLE.
REQ-006 CALC: the block SHALL perform exactly one restoring-division step per clock, for 32 clocks. Each step:
- Shift {R,Q} left by 1.
- Compute the trial value R minus |B| on 33 bits.
- If the trial is non-negative, load the trial into R and set Q[0]=1.
- Otherwise leave R unchanged and set Q[0]=0.
REQ-007 After the 32nd CALC step the block SHALL enter FIX.
REQ-008 In FIX, in one clock, the block SHALL:
- Load lo with Q, negated when the quotient sign is set.
- Load hi with R, negated when the remainder sign is set.
- Go to DONE.
REQ-009 In DONE the block SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-010 Latency: done SHALL be high in the cycle that follows the 34th rising edge after the edge that sampled start, counting the sampling edge as edge 0. The divide-by-zero path is the exception: done SHALL be high in the cycle that follows edge 1.
REQ-011 busy SHALL be high exactly while the state is CALC or FIX; busy SHALL be low in IDLE and DONE.
REQ-012 Results SHALL follow MIPS DIV semantics:
- The quotient truncates toward zero.
- The remainder takes the sign of the dividend.
- The identity lo*B + hi == A (mod 2^32) holds.
REQ-013 Overflow case: dividend=0x80000000 with divisor=0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no flag raised.
REQ-014 On divisor==0, hi and lo SHALL keep their previous values and div_zero SHALL be set to 1.
REQ-015 div_zero SHALL be cleared when the next valid request (divisor!=0) is accepted, and SHALL otherwise hold its value until reset.
REQ-016 hi and lo SHALL change only in FIX; they SHALL hold their values in all other states, including through a following division until that division reaches FIX.
REQ-017 start asserted in CALC, FIX or DONE SHALL be ignored; it SHALL not be queued and SHALL not alter the operation in progress.
REQ-018 A change on dividend or divisor after the sampling edge SHALL NOT affect the result.
REQ-019 A start held high continuously SHALL launch a new division on the first IDLE cycle after each DONE. Back-to-back throughput is therefore one result per 35 cycles.

Reset
REQ-020 While reset=0 the block SHALL, asynchronously:
- Force state to IDLE.
- Force hi, lo and the internal R, Q and counter to 0.
- Force busy, done and div_zero to 0.
REQ-021 Reset asserted mid-operation SHALL abort the division without producing a done pulse. The first start sampled after reset release SHALL begin a fresh division.
REQ-022 On reset release, the block SHALL accept start on the first rising edge at which reset=1.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- A=100, B=7, start pulse -> done 34 edges later; lo=14, hi=2; busy high for 33 cycles; div_zero=0.
- A=-100 (0xFFFFFF9C), B=7 -> lo=-14 (0xFFFFFFF2), hi=-2 (0xFFFFFFFE). Then A=100, B=-7 -> lo=-14, hi=2.
- A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Prior result lo=14, hi=2, then A=5, B=0 -> done on the following cycle, div_zero=1, lo=14, hi=2 unchanged. Then A=9, B=3 -> div_zero clears at acceptance, lo=3, hi=0.
- Start A=50, B=5; pulse start with A=1, B=1 at CALC cycle 10 -> final lo=10, hi=0; exactly one done pulse.
- Start A=50, B=5; assert reset at CALC cycle 20 -> hi=lo=0, busy=0 immediately, no done pulse. After release, A=7, B=2 -> lo=3, hi=1.
